// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings used by the control decoder and the
// execute-stage FSM state type.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SRL  = 4'b0100,
    ALU_SRA  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SLT  = 4'b1100,
    ALU_SLTU = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } exec_state_e;

  localparam int XLEN_DEFAULT = 32;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU ops plus illegal-op detection. Shift codes are legal here
// but produce 0; the iterative shifter in the parent supplies their result.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            illegal
);

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL, ALU_SRL, ALU_SRA: res = '0;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle logic/arith/compare ops, bit-serial shifts,
// valid/ready handshakes on both sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);

  exec_state_e     state_q, state_d;
  alu_op_e         kind_q, kind_d;
  logic            sign_q, sign_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] core_res;
  logic            core_illegal;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] first_step;
  logic [XLEN-1:0] next_step;

  alu_comb_core #(.XLEN(XLEN)) u_core (
    .op      (op),
    .a       (a),
    .b       (b),
    .res     (core_res),
    .illegal (core_illegal)
  );

  function automatic logic [XLEN-1:0] shift_step(input alu_op_e kind,
                                                 input logic [XLEN-1:0] val,
                                                 input logic sign);
    if (kind == ALU_SLL) return {val[XLEN-2:0], 1'b0};
    return {(kind == ALU_SRA) ? sign : 1'b0, val[XLEN-1:1]};
  endfunction

  assign shamt      = b[SW-1:0];
  assign first_step = shift_step(alu_op_e'(op), a, a[XLEN-1]);
  assign next_step  = shift_step(kind_q, work_q, sign_q);

  // The first shift happens during the accept cycle, so a shift of N bits
  // raises out_valid exactly N cycles after accept.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    sign_d    = sign_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_shift(op) && (shamt != '0)) begin
            kind_d = alu_op_e'(op);
            sign_d = a[XLEN-1];
            if (shamt == SW'(1)) begin
              result_d  = first_step;
              zero_d    = (first_step == '0);
              illegal_d = 1'b0;
              state_d   = DONE;
            end else begin
              work_d  = first_step;
              cnt_d   = shamt - SW'(1);
              state_d = SHIFT;
            end
          end else if (is_shift(op)) begin
            result_d  = a;
            zero_d    = (a == '0);
            illegal_d = 1'b0;
            state_d   = DONE;
          end else begin
            result_d  = core_res;
            zero_d    = (core_res == '0);
            illegal_d = core_illegal;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = next_step;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          result_d  = next_step;
          zero_d    = (next_step == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      kind_q    <= ALU_SLL;
      sign_q    <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      sign_q    <= sign_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the op table.
  task automatic ref_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(y[4:0]);
    ill = 1'b0;
    lat = 1;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = x ^ y;
      4'b0011: r = x << sh;
      4'b0100: r = x >> sh;
      4'b0101: r = $signed(x) >>> sh;
      4'b1100: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1101: r = (x < y) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    if ((o == 4'b0011 || o == 4'b0100 || o == 4'b0101) && sh > 0) lat = sh;
  endtask

  // Issue one op, wait for out_valid, check everything; optionally leave it in DONE.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hold);
    logic [31:0] er;
    logic        eill;
    int          elat;
    int          lat;
    ref_model(o, x, y, er, eill, elat);
    check("in_ready_before", {31'd0, in_ready}, 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("latency", lat, elat);
    check("result", result, er);
    check("zero", {31'd0, zero}, {31'd0, (er == 32'd0)});
    check("illegal", {31'd0, illegal}, {31'd0, eill});
    $display("op=%b a=%h b=%h -> result=%h zero=%b illegal=%b latency=%0d",
             o, x, y, result, zero, illegal, lat);
    if (!hold) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_after_take", {30'd0, in_ready, out_valid}, 32'd2);
    end
  endtask

  logic [3:0] op_list [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                               4'b0011, 4'b0100, 4'b0101, 4'b1100, 4'b1101, 4'b1111};

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; a = 32'd0; b = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(4'b0110, 32'd5, 32'd7, 1'b0);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(4'b1101, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(4'b0101, 32'h8000_0000, 32'd31, 1'b0);
    do_op(4'b0100, 32'h8000_0000, 32'h25, 1'b0);
    do_op(4'b0011, 32'h0000_1234, 32'd0, 1'b0);
    do_op(4'b0011, 32'h0000_0001, 32'd1, 1'b0);

    // Backpressure: hold the result while new requests are offered.
    do_op(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 4'b0010; a = $urandom; b = $urandom;
      tick();
      check("bp_result", result, 32'h00F0_00F0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
    check("bp_not_accepted", result, 32'h00F0_00F0);

    // Reset during a shift aborts it.
    op = 4'b0011; a = 32'h0000_0001; b = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_result", result, 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_valid", seen, 0);
    do_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = op_list[$urandom_range(0, 10)];
      if (ro == 4'b1111) ro = 4'($urandom_range(8, 11)) | 4'b1000 ^ 4'b0000;
      if (ro == 4'b1100 || ro == 4'b1101 || (ro & 4'b1000) == 4'b0000) ; else ro = 4'b1110;
      ra = $urandom;
      rb = $urandom;
      do_op(ro, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
